pool_row_scheduler: RTL and testbench

POOL_ROW_SCHEDULER -- requirements
Module: pool_row_scheduler

---
 rtl/pool_row_scheduler_if.sv | 29 ++
 rtl/pool_row_scheduler.sv | 131 +++++++++++++
 tb/tb_pool_row_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_row_scheduler_if.sv
// Handshake bundle between the pooling row scheduler, the layer controller,
// the row-buffer writer and the next-layer reader.
interface pool_row_scheduler_if #(
    parameter int ROW_WIDTH  = 10,
    parameter int WAIT_WIDTH = 16
);
    logic                  layer_start;
    logic [ROW_WIDTH-1:0]  layer_rows;
    logic                  layer_abort;
    logic                  writer_en;
    logic                  writer_done;
    logic                  bank_sel;
    logic [ROW_WIDTH-1:0]  row_idx;
    logic [1:0]            bank_full;
    logic [1:0]            bank_release;
    logic                  busy;
    logic                  layer_done;
    logic [WAIT_WIDTH-1:0] stall_cycles;

    modport master (
        output layer_start, layer_rows, layer_abort, writer_done, bank_release,
        input  writer_en, bank_sel, row_idx, bank_full, busy, layer_done, stall_cycles
    );

    modport slave (
        input  layer_start, layer_rows, layer_abort, writer_done, bank_release,
        output writer_en, bank_sel, row_idx, bank_full, busy, layer_done, stall_cycles
    );
endinterface

// File: rtl/pool_row_scheduler.sv
// Walks the output rows of a pooling layer, ping-ponging between two row-buffer
// banks and stalling whenever the target bank still holds unconsumed data.
module pool_row_scheduler #(
    parameter int ROW_WIDTH  = 10,
    parameter int WAIT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rstn,
    pool_row_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_BANK,
        ISSUE,
        RUN,
        COMMIT,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ROW_WIDTH-1:0]  r_rows;
    logic [ROW_WIDTH-1:0]  r_row_idx;
    logic [ROW_WIDTH-1:0]  w_row_inc;
    logic                  r_bank_sel;
    logic [1:0]            r_bank_full;
    logic [1:0]            w_set_mask;
    logic [WAIT_WIDTH-1:0] r_stall;
    logic                  r_writer_en;
    logic                  r_layer_done;
    logic                  r_busy;
    logic                  w_abort;
    logic                  w_commit;
    logic                  w_accept;
    logic                  w_stalling;

    assign w_abort    = bus.layer_abort && (r_state != IDLE);
    assign w_accept   = (r_state == IDLE) && bus.layer_start && (bus.layer_rows != '0);
    assign w_commit   = (r_state == COMMIT) && !w_abort;
    assign w_stalling = (r_state == WAIT_BANK) && r_bank_full[r_bank_sel] && !w_abort;
    assign w_row_inc  = r_row_idx + ROW_WIDTH'(1);
    assign w_set_mask = w_commit ? (r_bank_sel ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.layer_start) begin
                    w_next_state = (bus.layer_rows != '0) ? WAIT_BANK : DONE;
                end
            end
            WAIT_BANK: begin
                if (!r_bank_full[r_bank_sel]) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: w_next_state = RUN;
            RUN: begin
                if (bus.writer_done) begin
                    w_next_state = COMMIT;
                end
            end
            COMMIT:  w_next_state = (w_row_inc == r_rows) ? DONE : WAIT_BANK;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (w_abort) begin
            w_next_state = IDLE;
        end
    end

    // Pulses lag their state by one cycle so every output comes straight from a flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_writer_en  <= 1'b0;
            r_layer_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_writer_en  <= (r_state == ISSUE) && !w_abort;
            r_layer_done <= (r_state == DONE) && !w_abort;
            r_busy       <= (w_next_state != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rows     <= '0;
            r_row_idx  <= '0;
            r_bank_sel <= 1'b0;
            r_stall    <= '0;
        end else if (w_accept) begin
            r_rows     <= bus.layer_rows;
            r_row_idx  <= '0;
            r_bank_sel <= 1'b0;
            r_stall    <= '0;
        end else begin
            if (w_commit) begin
                r_row_idx  <= w_row_inc;
                r_bank_sel <= ~r_bank_sel;
            end
            if (w_stalling && (r_stall != '1)) begin
                r_stall <= r_stall + WAIT_WIDTH'(1);
            end
        end
    end

    // A commit only ever targets an empty bank, so a same-cycle release of it must lose.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bank_full <= 2'b00;
        end else begin
            r_bank_full <= (r_bank_full & ~bus.bank_release) | w_set_mask;
        end
    end

    assign bus.writer_en    = r_writer_en;
    assign bus.layer_done   = r_layer_done;
    assign bus.busy         = r_busy;
    assign bus.bank_sel     = r_bank_sel;
    assign bus.row_idx      = r_row_idx;
    assign bus.bank_full    = r_bank_full;
    assign bus.stall_cycles = r_stall;
endmodule

// File: tb/tb_pool_row_scheduler.sv
// Randomized scoreboard bench for pool_row_scheduler: a cycle-timeline model predicts
// every writer_en and layer_done pulse, and a monitor checks them as they appear.
module tb_pool_row_scheduler;
    localparam int RW       = 5;
    localparam int WW       = 5;
    localparam int MAXROWS  = (1 << RW) - 1;
    localparam int MAXSTALL = (1 << WW) - 1;

    typedef struct {
        int at;
        int row;
        int bank;
        int stall;
        bit full;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t wrQ[$];
    exp_t doneQ[$];
    int   relQ0[$];
    int   relQ1[$];
    int   freeT[2];
    int   idleFrom;
    logic [1:0] relNow;

    pool_row_scheduler_if #(.ROW_WIDTH(RW), .WAIT_WIDTH(WW)) bus ();

    pool_row_scheduler #(.ROW_WIDTH(RW), .WAIT_WIDTH(WW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " writer_en"}, bus.writer_en, 0);
        checkOutput({tag, " layer_done"}, bus.layer_done, 0);
        checkOutput({tag, " busy"}, bus.busy, 0);
        checkOutput({tag, " bank_sel"}, bus.bank_sel, 0);
        checkOutput({tag, " row_idx"}, bus.row_idx, 0);
        checkOutput({tag, " bank_full"}, bus.bank_full, 0);
        checkOutput({tag, " stall_cycles"}, bus.stall_cycles, 0);
    endtask

    function automatic exp_t mkExp(input int at, input int row, input int bank, input int stall, input bit full);
        exp_t it;
        it.at = at;
        it.row = row;
        it.bank = bank;
        it.stall = stall;
        it.full = full;
        return it;
    endfunction

    // A bank reads as full from the cycle after its commit until freeT.
    function automatic logic [1:0] fullModel();
        return {freeT[1] > cyc, freeT[0] > cyc};
    endfunction

    task automatic pushRel(input int bank, input int at);
        if (bank == 0) relQ0.push_back(at);
        else relQ1.push_back(at);
    endtask

    task automatic gotoCycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one layer open-loop from the timeline model; cutMode 1 aborts and
    // cutMode 2 resets during RUN of row cutRow.
    task automatic applyStimulus(input int rows, input int wMax, input int kMin, input int kMax,
                                 input bit spur, input int cutRow, input int cutMode);
        int s, x, t, e, d, c, b, k, stallAcc;
        s = (cyc + 1 > idleFrom) ? cyc + 1 : idleFrom;
        gotoCycle(s);
        bus.layer_start = 1'b1;
        bus.layer_rows  = RW'(rows);
        bus.layer_abort = spur;
        gotoCycle(s + 1);
        bus.layer_start = 1'b0;
        bus.layer_abort = 1'b0;
        bus.layer_rows  = RW'($urandom);
        if (rows == 0) begin
            doneQ.push_back(mkExp(s + 2, 0, 0, 0, 1'b0));
            idleFrom = s + 2;
            return;
        end
        stallAcc = 0;
        x = s + 1;
        for (int r = 0; r < rows; r++) begin
            b = r % 2;
            t = (freeT[b] > x) ? freeT[b] : x;
            stallAcc = stallAcc + (t - x);
            if (stallAcc > MAXSTALL) stallAcc = MAXSTALL;
            e = t + 2;
            wrQ.push_back(mkExp(e, r, b, stallAcc, 1'b1));
            if (spur && t > x) begin
                gotoCycle(x);
                bus.writer_done = 1'b1;
                gotoCycle(x + 1);
                bus.writer_done = 1'b0;
            end
            if (spur) begin
                gotoCycle(e - 1);
                bus.layer_start = 1'b1;
                bus.layer_rows  = RW'($urandom);
                gotoCycle(e);
                bus.layer_start = 1'b0;
            end
            if (r == cutRow) begin
                gotoCycle(e + 1);
                if (cutMode == 1) begin
                    bus.layer_abort = 1'b1;
                    gotoCycle(e + 2);
                    bus.layer_abort = 1'b0;
                    checkOutput("busy after abort", bus.busy, 0);
                    checkOutput("bank_full after abort", bus.bank_full, fullModel());
                    idleFrom = e + 2;
                end else begin
                    #2;
                    rstn = 1'b0;
                    #1;
                    checkResetValues("mid-layer reset");
                    @(posedge clk);
                    #1;
                    rstn = 1'b1;
                    relQ0.delete();
                    relQ1.delete();
                    freeT[0] = 0;
                    freeT[1] = 0;
                    idleFrom = cyc + 1;
                end
                return;
            end
            d = e + $urandom_range(wMax, 0);
            gotoCycle(d);
            bus.writer_done = 1'b1;
            gotoCycle(d + 1);
            bus.writer_done = 1'b0;
            c = d + 1;
            if (spur) pushRel(b, c);
            k = $urandom_range(kMax, kMin);
            pushRel(b, c + 1 + k);
            freeT[b] = c + 2 + k;
            x = d + 2;
        end
        doneQ.push_back(mkExp(x + 1, rows, 0, stallAcc, 1'b1));
        idleFrom = x + 1;
    endtask

    // Next-layer reader: plays back the scheduled bank_release pulses.
    initial begin
        bus.bank_release = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            relNow = 2'b00;
            while (relQ0.size() > 0 && relQ0[0] < cyc) void'(relQ0.pop_front());
            while (relQ1.size() > 0 && relQ1[0] < cyc) void'(relQ1.pop_front());
            if (relQ0.size() > 0 && relQ0[0] == cyc) begin
                relNow[0] = 1'b1;
                void'(relQ0.pop_front());
            end
            if (relQ1.size() > 0 && relQ1[0] == cyc) begin
                relNow[1] = 1'b1;
                void'(relQ1.pop_front());
            end
            bus.bank_release = relNow;
        end
    end

    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (bus.writer_en === 1'b1) begin
                if (wrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected writer_en: row_idx %0d at cycle %0d", bus.row_idx, cyc);
                end else begin
                    it = wrQ.pop_front();
                    checkOutput("writer_en cycle", cyc, it.at);
                    checkOutput("writer_en row_idx", bus.row_idx, it.row);
                    checkOutput("writer_en bank_sel", bus.bank_sel, it.bank);
                    checkOutput("writer_en stall_cycles", bus.stall_cycles, it.stall);
                end
            end
            if (bus.layer_done === 1'b1) begin
                if (doneQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected layer_done at cycle %0d", cyc);
                end else begin
                    it = doneQ.pop_front();
                    checkOutput("layer_done cycle", cyc, it.at);
                    if (it.full) begin
                        checkOutput("layer_done row_idx", bus.row_idx, it.row);
                        checkOutput("layer_done stall_cycles", bus.stall_cycles, it.stall);
                    end
                end
            end
        end
    end

    initial begin
        rstn             = 1'b1;
        bus.layer_start  = 1'b0;
        bus.layer_rows   = '0;
        bus.layer_abort  = 1'b0;
        bus.writer_done  = 1'b0;
        freeT[0]         = 0;
        freeT[1]         = 0;
        #2;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("power-on reset");
        rstn = 1'b1;
        idleFrom = cyc + 1;

        applyStimulus(3, 5, 0, 0, 1'b0, -1, 0);
        applyStimulus(0, 0, 0, 0, 1'b0, -1, 0);
        applyStimulus(4, 5, 18, 18, 1'b0, -1, 0);
        applyStimulus(5, 4, 0, 6, 1'b1, -1, 0);
        applyStimulus(3, 3, 0, 4, 1'b0, 1, 1);
        applyStimulus(2, 3, 0, 3, 1'b0, -1, 0);
        applyStimulus(4, 3, 0, 3, 1'b0, 2, 2);
        applyStimulus(3, 2, 0, 2, 1'b0, -1, 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus($urandom_range(8, 0), $urandom_range(6, 0), 0,
                          $urandom_range(12, 0), 1'($urandom_range(1, 0)), -1, 0);
        end
        applyStimulus(4, 2, 50, 60, 1'b0, -1, 0);
        applyStimulus(MAXROWS, 2, 0, 3, 1'b0, -1, 0);

        gotoCycle(idleFrom + 5);
        checkOutput("pending writer_en", wrQ.size(), 0);
        checkOutput("pending layer_done", doneQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
